// File: rtl/fwd_hazard_unit.sv
// Forwarding-select and load-use hazard unit: tracks in-flight destination registers
// over NSTAGES bypass stages and registers per-operand bypass selects for EX.
module fwd_hazard_unit #(
   parameter int NSTAGES    = 2,
   parameter int LOAD_STAGE = 2,
   parameter int NSRC       = 2,
   parameter int RW         = 5,
   parameter int CNTW       = 16,
   localparam int SELW      = $clog2(NSTAGES + 1)
) (
   input  logic                   CLK,
   input  logic                   nRST,
   input  logic                   en,
   input  logic                   flush,
   input  logic                   id_valid,
   input  logic [NSRC*RW-1:0]     id_rsel,
   input  logic                   id_wen,
   input  logic [RW-1:0]          id_wsel,
   input  logic                   id_load,
   output logic                   stall,
   output logic [NSRC*SELW-1:0]   fwd_sel,
   output logic [CNTW-1:0]        stall_cnt
);

   generate
      if ((NSTAGES < 1) || (LOAD_STAGE < 1) || (LOAD_STAGE > NSTAGES)) begin : g_param_check
         $error("fwd_hazard_unit: illegal NSTAGES=%0d / LOAD_STAGE=%0d", NSTAGES, LOAD_STAGE);
      end
   endgenerate

   typedef struct packed {
      logic          valid;
      logic [RW-1:0] wsel;
      logic          is_load;
   } entry_t;

   entry_t                 ent [NSTAGES];
   entry_t                 dec_entry;
   logic [NSRC*SELW-1:0]   cand;
   logic                   hazard;
   logic                   accept;

   // NOTE: every variable assigned in always_comb gets a default first, so no path
   // leaves it unassigned and no latch is inferred.
   always_comb begin
      hazard = 1'b0;
      cand   = '0;
      for (int i = 0; i < NSRC; i++) begin
         logic          found;
         logic [RW-1:0] rs;
         found = 1'b0;
         rs    = id_rsel[i*RW +: RW];
         // Scan youngest-first; the first hit shadows older stages and the register file.
         for (int j = 0; j < NSTAGES; j++) begin
            if (!found && ent[j].valid && (ent[j].wsel == rs) && (rs != '0)) begin
               found                  = 1'b1;
               cand[i*SELW +: SELW]   = SELW'(j + 1);
               if (ent[j].is_load && ((j + 1) < LOAD_STAGE))
                  hazard = 1'b1;
            end
         end
      end
   end

   assign stall  = id_valid & ~flush & hazard;
   assign accept = id_valid & ~stall & ~flush;

   always_comb begin
      dec_entry.valid   = id_wen & (id_wsel != '0);
      dec_entry.wsel    = id_wsel;
      dec_entry.is_load = id_load;
   end

   // NOTE: state updates use non-blocking assignments so every stage shifts from the
   // values held before the edge, independent of statement order.
   // NOTE: the tracking array is tiny and its valid bits gate all hazard logic, so it
   // is reset explicitly rather than treated as uninitialised storage.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         for (int j = 0; j < NSTAGES; j++) ent[j] <= '0;
         fwd_sel   <= '0;
         stall_cnt <= '0;
      end else if (en) begin
         for (int j = 1; j < NSTAGES; j++) ent[j] <= ent[j-1];
         ent[0]  <= accept ? dec_entry : '0;
         fwd_sel <= accept ? cand : '0;
         if (stall && (stall_cnt != '1))
            stall_cnt <= stall_cnt + 1'b1;
      end
   end

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Parametrised forwarding and load-use hazard unit for the pipelined datapath.
- Generalises the fixed two-source-stage forwarding select (stage 3 result / stage 4 result / register file) to NSTAGES bypass stages, NSRC source operands and a configurable load-data stage.
- Tracks in-flight destination registers in an internal shift pipeline and issues decode stalls on load-use hazards.
- Presents registered per-operand forwarding selects to EX. It also counts stall cycles.

Parameters:
- NSTAGES, 2, number of tracked stages ahead of decode (E[0]=EX … E[NSTAGES-1]); bypass sources 1..NSTAGES.
- LOAD_STAGE, 2, first bypass index (1..NSTAGES) at which load data is available.
- NSRC, 2, source operands per instruction.
- RW, 5, register select width.
- CNTW, 16, stall counter width.
- Derived: SELW = $clog2(NSTAGES+1).

Ports:
- CLK  in  1  clock, rising edge.
- nRST  in  1  asynchronous active-low reset.
- en  in  1  pipeline advance enable; 0 freezes all state.
- flush  in  1  squash decode instruction and E[0].
- id_valid  in  1  valid instruction in decode.
- id_rsel  in  NSRC*RW  source selects; operand i at [i*RW +: RW].
- id_wen  in  1  decode instruction writes a register.
- id_wsel  in  RW  destination register.
- id_load  in  1  decode instruction is a load.
- stall  out  1  hold decode/fetch, insert bubble (combinational).
- fwd_sel  out  NSRC*SELW  registered select for the instruction in EX; 0 = register file, k = bypass from stage k.
- stall_cnt  out  CNTW  saturating count of stall cycles.

Behaviour:
- Entry E[j] = {valid, wsel, is_load}. An entry is valid only if its instruction had wen=1 and wsel!=0; writes to r0 are never tracked.
- Match: source i matches E[j] when E[j].valid and E[j].wsel==rsel_i and rsel_i!=0. The youngest match (smallest j) wins. Older stages and the register file are ignored for that operand.
- Candidate select for source i = j+1 for the youngest match, otherwise 0. The producer is one stage further along when the consumer reaches EX.
- Hazard: the youngest match is a load and j+1 < LOAD_STAGE.
- stall = id_valid & ~flush & (hazard on any source). Computed combinationally in the same cycle.
- Clocked update when en=1:
  - E[j] <= E[j-1] for j>=1.
  - E[0] <= decode entry if id_valid & ~stall & ~flush, else bubble (valid=0).
  - fwd_sel <= candidates if the decode entry is accepted, else all 0.
  - If stall, stall_cnt increments; it saturates at all-ones.
- en=0: all registers hold. stall is still driven combinationally but the counter does not increment.
- flush=1 with en=1: E[0] becomes a bubble and fwd_sel is cleared. stall is forced to 0. Entries E[1..] advance normally.
- A stalled consumer re-evaluates every cycle. The producer advances one stage per en cycle, so the stall lasts exactly LOAD_STAGE-(j+1) cycles.
- Reset (async, any time including mid-stall):
  - All entries invalid, fwd_sel=0, stall_cnt=0.
  - stall therefore reads 0 until a new load is tracked.
- Invalid parameters: NSTAGES<1 or LOAD_STAGE outside 1..NSTAGES is illegal. Flag it with an elaboration-time error.

Test Plan:
- Reset then idle -> fwd_sel=0, stall=0, stall_cnt=0. Assert nRST mid-stall -> stall drops immediately, all entries cleared.
- Issue "add r3" then "sub r4,r3,r3" back-to-back (defaults) -> no stall; the cycle after sub is accepted, both fwd_sel fields = 1.
- Producer r7 followed by one independent instruction, then a consumer of r7 -> fwd_sel=2. With two independent instructions in between -> fwd_sel=0.
- "lw r5" then an immediate consumer of r5 -> stall=1 for exactly 1 cycle, stall_cnt=1, then fwd_sel=2. Repeat with LOAD_STAGE=NSTAGES=3 -> 2-cycle stall, fwd_sel=3.
- Consumer reads r0 after a write to r0 -> fwd_sel=0. Two in-flight writers of r9 -> select points at the younger one. Sources rs=r9, rt=r2 with only r9 pending -> fields = {0, 1}.
- en=0 for 3 cycles during a load-use stall -> entries, fwd_sel and stall_cnt hold; stall stays 1.
- flush during a stall -> stall=0, E[0] squashed, next fwd_sel=0.
- Force stall_cnt to all-ones with further stalls -> count holds at all-ones.
